rgb_layer_mux: RTL

Parametrised, pipelined pixel-colour multiplexer for the VGA display path. Sits between the pixel generators (text, graphics, cursor, overlay) and the DAC/RGB pins. Selects per pixel the highest-priority visible layer, honours a transparent colour key and a frame-based blink attribute, and forces black during blanking. Successor to the single-input combinational colour gate: N layers, registered output, aligned `video_on`.

---
 rtl/rgb_layer_mux.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rgb_layer_mux.sv
// Two-stage pixel colour multiplexer: layer visibility (enable, colour key, blink) is
// resolved in stage 1, priority selection and blanking in stage 2.

module rgb_layer_vis #(
   parameter int COLOR_W = 12
) (
   input  logic               en_i,
   input  logic               blink_i,
   input  logic               phase_i,
   input  logic [COLOR_W-1:0] color_i,
   input  logic [COLOR_W-1:0] key_i,
   output logic               vis_o
);
   assign vis_o = en_i & (color_i != key_i) & ~(blink_i & phase_i);
endmodule

module rgb_layer_mux #(
   parameter int COLOR_W      = 12,
   parameter int LAYERS       = 4,
   parameter int BLINK_FRAMES = 30,
   parameter int SEL_W        = $clog2(LAYERS+1)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      video_on,
   input  logic                      frame_tick,
   input  logic [LAYERS-1:0]         layer_en,
   input  logic [LAYERS-1:0]         layer_blink,
   input  logic [LAYERS*COLOR_W-1:0] layer_color,
   input  logic [COLOR_W-1:0]        key_color,
   input  logic [COLOR_W-1:0]        bg_color,
   output logic [COLOR_W-1:0]        RGB,
   output logic                      rgb_active,
   output logic [SEL_W-1:0]          sel_layer
);
   localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              blink_q, blink_d;

   // Blink half-period counter; the registered phase feeds stage 1, so a toggle
   // only affects pixels presented after the tick cycle.
   always_comb begin
      fcnt_d  = fcnt_q;
      blink_d = blink_q;
      if (frame_tick) begin
         if (fcnt_q == FCNT_W'(BLINK_FRAMES-1)) begin
            fcnt_d  = '0;
            blink_d = ~blink_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fcnt_q  <= '0;
         blink_q <= 1'b0;
      end else begin
         fcnt_q  <= fcnt_d;
         blink_q <= blink_d;
      end
   end

   logic [LAYERS-1:0][COLOR_W-1:0] lay_col;
   logic [LAYERS-1:0]              vis_d;

   assign lay_col = layer_color;

   generate
      for (genvar g = 0; g < LAYERS; g++) begin : g_lane
         rgb_layer_vis #(.COLOR_W(COLOR_W)) u_vis (
            .en_i    (layer_en[g]),
            .blink_i (layer_blink[g]),
            .phase_i (blink_q),
            .color_i (lay_col[g]),
            .key_i   (key_color),
            .vis_o   (vis_d[g])
         );
      end
   endgenerate

   // vld_pipe_q[k] is video_on delayed by k cycles.
   logic [2:1]                     vld_pipe_q;
   logic [LAYERS-1:0][COLOR_W-1:0] col1_q;
   logic [COLOR_W-1:0]             bg1_q;
   logic [LAYERS-1:0]              vis1_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe_q <= '0;
         col1_q     <= '0;
         bg1_q      <= '0;
         vis1_q     <= '0;
      end else begin
         vld_pipe_q <= {vld_pipe_q[1], video_on};
         col1_q     <= lay_col;
         bg1_q      <= bg_color;
         vis1_q     <= vis_d;
      end
   end

   logic [COLOR_W-1:0] rgb_d, rgb_q;
   logic [SEL_W-1:0]   sel_d, sel_q;

   // Scan from the lowest priority upward so the lowest visible index wins.
   always_comb begin
      rgb_d = '0;
      sel_d = '0;
      if (vld_pipe_q[1]) begin
         rgb_d = bg1_q;
         sel_d = SEL_W'(LAYERS);
         for (int i = LAYERS-1; i >= 0; i--) begin
            if (vis1_q[i]) begin
               rgb_d = col1_q[i];
               sel_d = SEL_W'(i);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rgb_q <= '0;
         sel_q <= '0;
      end else begin
         rgb_q <= rgb_d;
         sel_q <= sel_d;
      end
   end

   assign RGB        = rgb_q;
   assign sel_layer  = sel_q;
   assign rgb_active = vld_pipe_q[2];
endmodule
